// File: rtl/mdu_scheduler_pkg.sv
// Shared MDU definitions: operation encoding, scheduler states,
// default latencies and small decode helpers.
package mdu_scheduler_pkg;

  localparam int MUL_LATENCY_DEF = 5;
  localparam int DIV_LATENCY_DEF = 10;
  localparam int CNT_W           = 4;
  localparam int STALL_CNT_W     = 16;

  typedef enum logic [2:0] {
    MDU_START_SIGNED_MUL   = 3'd0,
    MDU_START_UNSIGNED_MUL = 3'd1,
    MDU_START_SIGNED_DIV   = 3'd2,
    MDU_START_UNSIGNED_DIV = 3'd3,
    MDU_READ_HI            = 3'd4,
    MDU_READ_LO            = 3'd5,
    MDU_WRITE_HI           = 3'd6,
    MDU_WRITE_LO           = 3'd7
  } mdu_operation_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } sched_state_t;

  function automatic logic is_mul_start(
    input mdu_operation_t op
  );
    return (op == MDU_START_SIGNED_MUL) ||
           (op == MDU_START_UNSIGNED_MUL);
  endfunction

  function automatic logic is_div_start(
    input mdu_operation_t op
  );
    return (op == MDU_START_SIGNED_DIV) ||
           (op == MDU_START_UNSIGNED_DIV);
  endfunction

  function automatic logic is_hilo_write(
    input mdu_operation_t op
  );
    return (op == MDU_WRITE_HI) ||
           (op == MDU_WRITE_LO);
  endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// Busy-window down-counter: load, decrement to zero,
// and flag the final busy cycle.
module mdu_busy_counter
  import mdu_scheduler_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/mdu_scheduler.sv
// Issues MDU start/write strobes and stalls the pipeline
// while a multiply or divide is still producing HI/LO.
module mdu_scheduler
  import mdu_scheduler_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  input  mdu_operation_t         req_op,
  input  logic                   flush,
  output logic                   mdu_start,
  output logic                   mdu_write,
  output mdu_operation_t         mdu_op,
  output logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LATENCY);

  sched_state_t     state;
  sched_state_t     state_nxt;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_is_one;

  assign mdu_op = req_op;
  assign busy   = (state != IDLE);

  // reset gates the strobes so nothing leaks out while held
  assign stall  = reset && req_valid && !flush && busy;
  assign accept = reset && req_valid && !flush && !stall;

  assign mdu_start = accept &&
                     (is_mul_start(req_op) ||
                      is_div_start(req_op));
  assign mdu_write = accept && is_hilo_write(req_op);
  assign done      = busy && cnt_is_one;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (1'b1)
      (state == IDLE): begin
        if (accept && is_mul_start(req_op)) begin
          state_nxt    = MUL_BUSY;
          cnt_load     = 1'b1;
          cnt_load_val = MUL_LD;
        end else if (accept && is_div_start(req_op)) begin
          state_nxt    = DIV_BUSY;
          cnt_load     = 1'b1;
          cnt_load_val = DIV_LD;
        end
      end
      (state != IDLE): begin
        if (cnt_is_one) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  mdu_busy_counter u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (busy),
    .cnt      (cnt),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed bench for mdu_scheduler: stall timing, strobes,
// flush, async reset and stall counter saturation.
module tb_mdu_scheduler;
  import mdu_scheduler_pkg::*;

  logic           clock;
  logic           reset;
  logic           req_valid;
  mdu_operation_t req_op;
  logic           flush;
  logic           mdu_start;
  logic           mdu_write;
  mdu_operation_t mdu_op;
  logic           stall;
  logic           busy;
  logic           done;
  logic [15:0]    stall_count;

  int total;
  int passed;

  mdu_scheduler #(
    .MUL_LATENCY (5),
    .DIV_LATENCY (10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .flush       (flush),
    .mdu_start   (mdu_start),
    .mdu_write   (mdu_write),
    .mdu_op      (mdu_op),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .stall_count (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // inputs change at the falling edge, outputs sampled 1ns later
  task automatic cyc(
    input logic           v,
    input mdu_operation_t o,
    input logic           f
  );
    @(negedge clock);
    req_valid = v;
    req_op    = o;
    flush     = f;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b0;
    req_valid = 1'b0;
    flush     = 1'b0;
    req_op    = MDU_READ_HI;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset     = 1'b0;
    req_valid = 1'b1;
    flush     = 1'b0;
    req_op    = MDU_START_SIGNED_MUL;
    #1;
    total++; if (mdu_start !== 1'b0) $display("FAIL rst_start got %b want 0", mdu_start); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passed++;
    total++; if (stall_count !== 16'h0) $display("FAIL rst_cnt got %h want 0000", stall_count); else passed++;
    total++; if (mdu_op !== MDU_START_SIGNED_MUL) $display("FAIL rst_op got %0d want 0", mdu_op); else passed++;
    req_op = MDU_WRITE_HI;
    #1;
    total++; if (mdu_write !== 1'b0) $display("FAIL rst_write got %b want 0", mdu_write); else passed++;
    total++; if (mdu_op !== MDU_WRITE_HI) $display("FAIL rst_op2 got %0d want 6", mdu_op); else passed++;
    @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rst_hold_busy got %b want 0", busy); else passed++;
    #2;
    reset = 1'b1;
    cyc(1'b1, MDU_START_SIGNED_MUL, 1'b0);
    total++; if (mdu_start !== 1'b1) $display("FAIL first_start got %b want 1", mdu_start); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL first_stall got %b want 0", stall); else passed++;
    cyc(1'b0, MDU_READ_LO, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL first_busy got %b want 1", busy); else passed++;
  endtask

  task automatic test_mul_mflo();
    do_reset();
    cyc(1'b1, MDU_START_SIGNED_MUL, 1'b0);
    total++; if (mdu_start !== 1'b1) $display("FAIL mul_start got %b want 1", mdu_start); else passed++;
    for (int c = 1; c <= 5; c++) begin
      cyc(1'b1, MDU_READ_LO, 1'b0);
      total++; if (stall !== 1'b1) $display("FAIL mul_stall c%0d got %b want 1", c, stall); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL mul_busy c%0d got %b want 1", c, busy); else passed++;
      total++; if (done !== (c == 5)) $display("FAIL mul_done c%0d got %b want %b", c, done, (c == 5)); else passed++;
    end
    cyc(1'b1, MDU_READ_LO, 1'b0);
    total++; if (stall !== 1'b0) $display("FAIL mflo_acc got %b want 0", stall); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mflo_busy got %b want 0", busy); else passed++;
    total++; if (mdu_start !== 1'b0) $display("FAIL mflo_start got %b want 0", mdu_start); else passed++;
    total++; if (mdu_write !== 1'b0) $display("FAIL mflo_write got %b want 0", mdu_write); else passed++;
    total++; if (stall_count !== 16'd5) $display("FAIL mul_cnt got %0d want 5", stall_count); else passed++;
    cyc(1'b0, MDU_READ_LO, 1'b0);
    total++; if (busy !== 1'b0) $display("FAIL read_nostate got %b want 0", busy); else passed++;
  endtask

  task automatic test_div_add();
    do_reset();
    cyc(1'b1, MDU_START_UNSIGNED_DIV, 1'b0);
    total++; if (mdu_start !== 1'b1) $display("FAIL divu_start got %b want 1", mdu_start); else passed++;
    for (int c = 1; c <= 10; c++) begin
      cyc(c >= 4, MDU_READ_HI, 1'b0);
      total++; if (stall !== (c >= 4)) $display("FAIL div_stall c%0d got %b want %b", c, stall, (c >= 4)); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL div_busy c%0d got %b want 1", c, busy); else passed++;
      total++; if (done !== (c == 10)) $display("FAIL div_done c%0d got %b want %b", c, done, (c == 10)); else passed++;
    end
    cyc(1'b1, MDU_READ_HI, 1'b0);
    total++; if (stall !== 1'b0) $display("FAIL mfhi_acc got %b want 0", stall); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL div_idle got %b want 0", busy); else passed++;
    total++; if (stall_count !== 16'd7) $display("FAIL div_cnt got %0d want 7", stall_count); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    cyc(1'b1, MDU_START_SIGNED_MUL, 1'b1);
    total++; if (mdu_start !== 1'b0) $display("FAIL fl_start got %b want 0", mdu_start); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL fl_stall got %b want 0", stall); else passed++;
    cyc(1'b1, MDU_WRITE_HI, 1'b0);
    total++; if (busy !== 1'b0) $display("FAIL fl_busy got %b want 0", busy); else passed++;
    total++; if (mdu_write !== 1'b1) $display("FAIL mthi_write got %b want 1", mdu_write); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL mthi_stall got %b want 0", stall); else passed++;
    total++; if (mdu_start !== 1'b0) $display("FAIL mthi_start got %b want 0", mdu_start); else passed++;
    cyc(1'b1, MDU_START_UNSIGNED_MUL, 1'b0);
    total++; if (mdu_start !== 1'b1) $display("FAIL mulu_start got %b want 1", mdu_start); else passed++;
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b1, (c == 1) ? MDU_READ_LO : MDU_WRITE_LO, 1'b1);
      total++; if (stall !== 1'b0) $display("FAIL flbusy_stall c%0d got %b want 0", c, stall); else passed++;
      total++; if (mdu_write !== 1'b0) $display("FAIL flbusy_write c%0d got %b want 0", c, mdu_write); else passed++;
      total++; if (busy !== (c <= 5)) $display("FAIL flbusy_busy c%0d got %b want %b", c, busy, (c <= 5)); else passed++;
      total++; if (done !== (c == 5)) $display("FAIL flbusy_done c%0d got %b want %b", c, done, (c == 5)); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1'b1, MDU_START_SIGNED_DIV, 1'b0);
    total++; if (mdu_start !== 1'b1) $display("FAIL div_start got %b want 1", mdu_start); else passed++;
    for (int c = 1; c <= 3; c++) begin
      cyc(1'b1, MDU_READ_HI, 1'b0);
      total++; if (done !== 1'b0) $display("FAIL mid_done c%0d got %b want 0", c, done); else passed++;
    end
    total++; if (stall_count !== 16'd2) $display("FAIL mid_cnt_pre got %0d want 2", stall_count); else passed++;
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else passed++;
    total++; if (stall_count !== 16'd0) $display("FAIL mid_cnt got %0d want 0", stall_count); else passed++;
    total++; if (done !== 1'b0) $display("FAIL mid_done_rst got %b want 0", done); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL mid_stall got %b want 0", stall); else passed++;
    @(negedge clock);
    #2;
    reset = 1'b1;
    cyc(1'b1, MDU_START_SIGNED_MUL, 1'b0);
    total++; if (mdu_start !== 1'b1) $display("FAIL mid_mul_start got %b want 1", mdu_start); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL mid_mul_stall got %b want 0", stall); else passed++;
    total++; if (done !== 1'b0) $display("FAIL mid_done_post got %b want 0", done); else passed++;
    cyc(1'b0, MDU_READ_HI, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL mid_mul_busy got %b want 1", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      cyc(1'b1, MDU_START_SIGNED_MUL, 1'b0);
      total++; if (mdu_start !== (c == 0 || c == 6)) $display("FAIL b2b_start c%0d got %b want %b", c, mdu_start, (c == 0 || c == 6)); else passed++;
      total++; if (stall !== (c >= 1 && c <= 5)) $display("FAIL b2b_stall c%0d got %b want %b", c, stall, (c >= 1 && c <= 5)); else passed++;
    end
    cyc(1'b0, MDU_READ_HI, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else passed++;
  endtask

  task automatic test_saturation();
    int p;
    int n;
    logic [15:0] exp_cnt;
    do_reset();
    p = 0;
    exp_cnt = 16'h0;
    // continuous DIVs: one accept then ten stalled cycles
    while (exp_cnt != 16'hFFFE) begin
      cyc(1'b1, MDU_START_SIGNED_DIV, 1'b0);
      if (p != 0) exp_cnt++;
      p = (p == 10) ? 0 : p + 1;
    end
    cyc(1'b1, MDU_START_SIGNED_DIV, 1'b0);
    total++; if (stall_count !== 16'hFFFE) $display("FAIL sat_pre got %h want fffe", stall_count); else passed++;
    n = (p != 0) ? 1 : 0;
    p = (p == 10) ? 0 : p + 1;
    while (n < 3) begin
      cyc(1'b1, MDU_START_SIGNED_DIV, 1'b0);
      if (p != 0) n++;
      p = (p == 10) ? 0 : p + 1;
    end
    cyc(1'b0, MDU_READ_HI, 1'b0);
    total++; if (stall_count !== 16'hFFFF) $display("FAIL sat_hit got %h want ffff", stall_count); else passed++;
    for (int c = 0; c < 12; c++) begin
      cyc(1'b1, MDU_START_SIGNED_DIV, 1'b0);
    end
    total++; if (stall_count !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", stall_count); else passed++;
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    flush     = 1'b0;
    req_op    = MDU_READ_HI;
    test_reset();
    test_mul_mflo();
    test_div_add();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mdu_scheduler.md
MDU_SCHEDULER -- requirements
Module: mdu_scheduler

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 5, busy cycles of a multiply.
REQ-002 SHALL have parameter DIV_LATENCY, default 10, busy cycles of a divide; both parameters are legal in the range 1..15.
REQ-003 clock  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  EX-stage instruction uses the MDU this cycle.
REQ-006 req_op  input  mdu_operation_t  MDU operation of the EX instruction (start mul/div, read HI/LO, write HI/LO).
REQ-007 flush  input  1  kill the EX instruction this cycle.
REQ-008 mdu_start  output  1  one-cycle start pulse to the MDU.
REQ-009 mdu_write  output  1  one-cycle HI/LO write strobe (MTHI/MTLO).
REQ-010 mdu_op  output  mdu_operation_t  operation forwarded to the MDU, equal to req_op.
REQ-011 stall  output  1  hold IF/ID/EX; insert a bubble into MEM.
REQ-012 busy  output  1  a multiply or divide is in flight.
REQ-013 done  output  1  last busy cycle; HI/LO valid from the next edge.
REQ-014 stall_count  output  16  saturating count of stalled cycles.

Function
REQ-015 SHALL implement the states IDLE, MUL_BUSY and DIV_BUSY, with a 4-bit down-counter cnt.
REQ-016 A request is accepted when req_valid=1, flush=0 and stall=0.
REQ-017 stall SHALL be a combinational output: 1 when req_valid=1, flush=0, state!=IDLE and req_op is any MDU operation; otherwise 0.
REQ-018 A non-MDU instruction (req_valid=0) SHALL never stall, including while busy.
REQ-019 mdu_start SHALL be combinational: 1 when an accepted request has req_op = MDU_START_SIGNED_MUL, MDU_START_UNSIGNED_MUL, MDU_START_SIGNED_DIV or MDU_START_UNSIGNED_DIV.
REQ-020 mdu_write SHALL be combinational: 1 when an accepted request has req_op = MDU_WRITE_HI or MDU_WRITE_LO.
REQ-021 Accepted MDU_READ_HI and MDU_READ_LO requests SHALL produce no pulse and no state change.
REQ-022 On an accepted multiply start: next state is MUL_BUSY and cnt <= MUL_LATENCY. On an accepted divide start: next state is DIV_BUSY and cnt <= DIV_LATENCY.
REQ-023 In a BUSY state, cnt SHALL decrement each cycle. When cnt==1: done=1 and next state is IDLE.
REQ-024 For a start accepted at cycle T: busy=1 in cycles T+1..T+L, done=1 at T+L, and a dependent MFHI/MFLO is accepted at T+L+1.
REQ-025 A request arriving in the done cycle SHALL still stall.
REQ-026 flush SHALL suppress acceptance, mdu_start, mdu_write and stall in the same cycle only.
REQ-027 flush SHALL NOT abort an operation already in flight.
REQ-028 stall_count SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF without wrapping.
REQ-029 With flush=1 and req_valid=1 simultaneously, flush SHALL win.

Reset
REQ-030 On reset=0, immediately (asynchronously): state=IDLE, cnt=0, stall_count=0.
REQ-031 While reset=0, all outputs SHALL be 0, except mdu_op, which follows req_op.
REQ-032 Asserting reset mid-operation SHALL discard the in-flight operation without asserting done.
REQ-033 The first request after reset is released SHALL be accepted without stall.

Structure
REQ-034 mdu_operation_t, the scheduler state enum, and the default values of MUL_LATENCY and DIV_LATENCY SHALL live in the shared definitions package used by the MDU and the control unit.
REQ-035 The down-counter with load, decrement and ==1 detect SHALL be a sub-module named mdu_busy_counter; everything else stays in mdu_scheduler.

Verification
REQ-036 MULT accepted at cycle 0, MFLO presented from cycle 1 -> stall=1 in cycles 1..5, done=1 at cycle 5, MFLO accepted at cycle 6, stall_count=5.
REQ-037 DIVU accepted at 0, ADD (req_valid=0) at 1..3, then MFHI -> no stall for the ADDs, MFHI stalls through cycle 10, busy=1 in cycles 1..10.
REQ-038 MULT with flush=1 at cycle 0 -> mdu_start=0, busy stays 0; MTHI at cycle 1 -> mdu_write=1, stall=0.
REQ-039 DIV accepted at 0, reset pulsed low at cycle 4 -> busy=0 and stall_count=0 immediately, done never asserted, MULT after release accepted with mdu_start=1.
REQ-040 Back-to-back MULT, MULT -> second MULT stalls in cycles 1..5 and is accepted at cycle 6 with mdu_start=1.
REQ-041 Stall_count preloaded to 16'hFFFE, then 3 stalled cycles -> stall_count reads 16'hFFFF and stays there.
